// File: rtl/stream_extrema_tracker.sv
// Frame-based running max/min tracker with first-max index and max multiplicity.
// Compares per frame as unsigned (BCS) or two's complement (TCS), latched on the first beat.
module stream_extrema_tracker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tcs_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_max_cnt,
    output logic [CNT_W-1:0] out_len
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAccum = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, len_q, len_d;
    logic             in_ready_q, out_valid_q;
    logic             accept, load_out;

    // Same GT relation as the upstream magnitude comparator.
    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic m);
        if (m) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    assign accept   = in_valid & in_ready_q;
    assign load_out = accept & in_last;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        max_d   = max_q;
        min_d   = min_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (accept) begin
            if (state_q == StIdle) begin
                mode_d = tcs_mode;
                max_d  = in_data;
                min_d  = in_data;
                idx_d  = '0;
                cnt_d  = CntOne;
                len_d  = CntOne;
            end else begin
                if (gt(in_data, max_q, mode_q)) begin
                    max_d = in_data;
                    idx_d = len_q;
                    cnt_d = CntOne;
                end else if (in_data == max_q) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (gt(min_q, in_data, mode_q)) begin
                    min_d = in_data;
                end
                len_d = sat_inc(len_q);
            end
            state_d = in_last ? StHold : StAccum;
        end else if (state_q == StHold && out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            max_q       <= max_d;
            min_q       <= min_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            in_ready_q  <= (state_d != StHold);
            out_valid_q <= (state_d == StHold);
        end
    end

    // Result registers only change when a new frame completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_max_cnt <= '0;
            out_len     <= '0;
        end else if (load_out) begin
            out_max     <= max_d;
            out_min     <= min_d;
            out_max_idx <= idx_d;
            out_max_cnt <= cnt_d;
            out_len     <= len_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// Directed bench for stream_extrema_tracker: table of frames plus hand-written
// backpressure, mode-change, reset and counter-saturation sequences.
module tb_stream_extrema_tracker;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tcs_mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_max, out_min;
    logic [CW-1:0] out_max_idx, out_max_cnt, out_len;

    int total = 0;
    int bad = 0;

    stream_extrema_tracker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tcs_mode   (tcs_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_min    (out_min),
        .out_max_idx(out_max_idx),
        .out_max_cnt(out_max_cnt),
        .out_len    (out_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            n;
        logic          mode;
        logic [31:0]   data;   // first beat in [31:24]
        logic [W-1:0]  emax;
        logic [W-1:0]  emin;
        logic [CW-1:0] eidx;
        logic [CW-1:0] ecnt;
        logic [CW-1:0] elen;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic mode, input logic [W-1:0] d, input logic last);
        int guard = 0;
        tcs_mode = mode;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] emax,
                                input logic [W-1:0] emin, input logic [CW-1:0] eidx,
                                input logic [CW-1:0] ecnt, input logic [CW-1:0] elen);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_max"}, 32'(out_max), 32'(emax));
        check({tag, "_min"}, 32'(out_min), 32'(emin));
        check({tag, "_idx"}, 32'(out_max_idx), 32'(eidx));
        check({tag, "_cnt"}, 32'(out_max_cnt), 32'(ecnt));
        check({tag, "_len"}, 32'(out_len), 32'(elen));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        tbl[0] = '{4, 1'b0, 32'h03C8C807, 8'hC8, 8'h03, 4'd1, 4'd2, 4'd4};
        tbl[1] = '{4, 1'b1, 32'h03C8C807, 8'h07, 8'hC8, 4'd3, 4'd1, 4'd4};
        tbl[2] = '{1, 1'b1, 32'h80000000, 8'h80, 8'h80, 4'd0, 4'd1, 4'd1};
        tbl[3] = '{3, 1'b0, 32'h05050500, 8'h05, 8'h05, 4'd0, 4'd3, 4'd3};
        tbl[4] = '{4, 1'b1, 32'h807FFF7F, 8'h7F, 8'h80, 4'd1, 4'd2, 4'd4};
        tbl[5] = '{4, 1'b0, 32'h00FF00FF, 8'hFF, 8'h00, 4'd1, 4'd2, 4'd4};

        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_max", 32'(out_max), 32'd0);
        check("rst_len", 32'(out_len), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_ready_hold", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_rise", 32'(in_ready), 32'd1);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < tbl[v].n; b++) begin
                logic [31:0] dw;
                dw = tbl[v].data;
                beat(tbl[v].mode, dw[31 - 8*b -: 8], (b == tbl[v].n - 1));
            end
            check_result($sformatf("vec%0d", v), tbl[v].emax, tbl[v].emin, tbl[v].eidx,
                         tbl[v].ecnt, tbl[v].elen);
            release_result($sformatf("vec%0d", v));
        end

        // Backpressure: results stable, no beats consumed
        beat(1'b0, 8'h11, 1'b0);
        beat(1'b0, 8'h22, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_max", 32'(out_max), 32'h22);
            check("bp_len", 32'(out_len), 32'd2);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_result("bp");
        check("bp_idle_max", 32'(out_max), 32'h22);
        beat(1'b0, 8'hAA, 1'b1);
        check_result("bp_next", 8'hAA, 8'hAA, 4'd0, 4'd1, 4'd1);
        release_result("bp_next");

        // Mode change mid-frame is ignored
        beat(1'b0, 8'h7F, 1'b0);
        beat(1'b1, 8'h80, 1'b1);
        check_result("mode", 8'h80, 8'h7F, 4'd1, 4'd1, 4'd2);
        release_result("mode");

        // Counter saturation: cnt and len clamp at 15
        for (int b = 0; b < 20; b++) beat(1'b0, 8'h33, (b == 19));
        check_result("sat_cnt", 8'h33, 8'h33, 4'd0, 4'd15, 4'd15);
        release_result("sat_cnt");
        // New max after len saturated: idx clamps too
        for (int b = 0; b < 20; b++) begin
            logic [W-1:0] d;
            d = (b == 19) ? 8'h01 : ((b >= 17) ? 8'h20 : 8'h10);
            beat(1'b0, d, (b == 19));
        end
        check_result("sat_idx", 8'h20, 8'h01, 4'd15, 4'd2, 4'd15);
        release_result("sat_idx");

        // Reset mid-frame discards the partial frame
        beat(1'b0, 8'h44, 1'b0);
        beat(1'b0, 8'h55, 1'b0);
        reset = 1'b0;
        #2;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_max", 32'(out_max), 32'd0);
        check("mid_rst_min", 32'(out_min), 32'd0);
        check("mid_rst_cnt", 32'(out_max_cnt), 32'd0);
        check("mid_rst_len", 32'(out_len), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        beat(1'b0, 8'h05, 1'b1);
        check_result("post_rst", 8'h05, 8'h05, 4'd0, 4'd1, 4'd1);
        release_result("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_extrema_tracker.md
# stream_extrema_tracker

Sequential consumer of the 8-bit magnitude comparator. It accepts a stream of samples framed by a `last` marker and tracks the running maximum and minimum, the index of the first maximum, and the maximum's multiplicity. Results are presented on a valid/ready output port. Operands are compared either as unsigned binary (BCS) or two's complement (TCS), selected per frame. It sits directly downstream of the comparator datapath and reuses its EQ/GT semantics for every decision.

## Interface
- `WIDTH`, 8, sample width in bits.
- `CNT_W`, 16, width of the length, index and count fields.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `tcs_mode`  in  1  0 = unsigned (BCS) compare, 1 = two's-complement (TCS) compare.
- `in_valid`  in  1  sample present.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  WIDTH  sample.
- `in_last`  in  1  marks the final sample of a frame.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_max`  out  WIDTH  frame maximum.
- `out_min`  out  WIDTH  frame minimum.
- `out_max_idx`  out  CNT_W  0-based index of the first sample equal to `out_max`.
- `out_max_cnt`  out  CNT_W  number of samples equal to `out_max`.
- `out_len`  out  CNT_W  samples in the frame.

## Operation
- Beat accepted when `in_valid & in_ready`. Result transferred when `out_valid & out_ready`.
- States and transitions:
  - IDLE: no frame open; `in_ready`=1. The first accepted beat goes to ACCUM, or to HOLD if `in_last`=1.
  - ACCUM: frame open; `in_ready`=1. An accepted beat with `in_last`=1 goes to HOLD.
  - HOLD: `out_valid`=1, `in_ready`=0. A result transfer goes to IDLE.
- First beat of a frame:
  - Loads max=min=`in_data`, idx=0, cnt=1, len=1.
  - Latches `tcs_mode` for the frame. Changes to `tcs_mode` later in the frame are ignored.
- Each later beat uses the latched mode and is compared against the registers before that beat's update:
  - If `in_data` GT max: max=`in_data`, idx=len, cnt=1.
  - Else if `in_data` EQ max: cnt=cnt+1; idx is unchanged, so the first occurrence is kept.
  - If min GT `in_data`: min=`in_data`.
  - len=len+1.
- EQ/GT definition: identical to the comparator. EQ is bitwise equality. GT is the unsigned relation when mode=0 and the signed relation when mode=1.
- Saturation:
  - len, idx and cnt saturate at 2^CNT_W−1 and never wrap.
  - The frame continues past saturation; max and min stay correct.
- `in_valid` is ignored in HOLD. Data beats presented there are not consumed.

## Timing
- Reset (`reset`=0, asynchronous):
  - State = IDLE.
  - `out_valid`=0, `in_ready`=0 while reset is asserted.
  - `out_max`, `out_min`, `out_max_idx`, `out_max_cnt` and `out_len` all = 0.
- `in_ready` rises on the first `clk` edge after reset deasserts.
- Reset mid-frame or in HOLD discards the partial frame or pending result. No output is produced for it.
- Latency: `out_valid` asserts on the edge that accepts the `in_last` beat. Results are visible in the following cycle.
- All outputs are registered and held stable while `out_valid`=1 and `out_ready`=0.
- On the result-transfer edge the state returns to IDLE. `in_ready`=1 from the next cycle; there is no same-cycle overlap of output transfer and input accept.
- Throughput: one sample per cycle within a frame. Minimum frame turnaround is frame length + 1 cycles when `out_ready` is held high.
- Output data is unchanged after returning to IDLE. It is overwritten only when the next result is registered.

## Test plan
- Unsigned frame: mode 0; 0x03, 0xC8, 0xC8, 0x07 (last). Expect max=0xC8, min=0x03, idx=1, cnt=2, len=4, `out_valid` the cycle after the last beat.
- Signed frame: same bytes, mode 1. Expect max=0x07, min=0xC8, idx=3, cnt=1, len=4.
- Single-sample frame: mode 1; 0x80 with `in_last`=1. Expect max=min=0x80, idx=0, cnt=1, len=1, direct IDLE→HOLD.
- Backpressure: hold `out_ready`=0 for 5 cycles while `in_valid`=1 with new data. Expect outputs stable, `in_ready`=0, no beats consumed. Expect IDLE one cycle after `out_ready`=1.
- Mode change mid-frame: start mode 0 with 0x7F, switch `tcs_mode` to 1, send 0x80 (last). Expect max=0x80, min=0x7F, since the frame stays unsigned.
- Reset mid-frame: after 2 beats assert `reset`=0 for one cycle. Expect outputs = 0 and `out_valid`=0 immediately. A new frame 0x05 (last) yields len=1, max=min=0x05.
